// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, branch-target LUT and mode/halt handling
module fetch_unit #(
  parameter int              PC_W    = 10,
  parameter int              IW      = 9,
  parameter int              LUT_AW  = 4,
  parameter logic [IW-1:0]   MODE_SW = 9'h1FE,
  parameter logic [IW-1:0]   HALT    = 9'h1FF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [LUT_AW-1:0] branch_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_widx,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [IW-1:0]     imem_data,
  output logic [IW-1:0]     mach_code,
  output logic              mode,
  output logic              instr_valid,
  output logic [PC_W-1:0]   pc,
  output logic              done
);

  localparam int LUT_N = 2 ** LUT_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   lut [LUT_N];

  // The ROM is read combinationally at the current PC
  assign imem_addr = pc;

  // Branch-target table: written in any state, read below with its pre-write contents
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_widx] <= lut_wdata;
    end
  end

  // Fetch sequencer: PC update, registered instruction/mode and halt tracking
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      pc          <= '0;
      mach_code   <= '0;
      mode        <= 1'b0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state <= RUN;
            pc    <= '0;
          end
        end
        RUN: begin
          if (Start) begin
            pc          <= '0;
            mode        <= 1'b0;
            instr_valid <= 1'b0;
            mach_code   <= '0;
          end else if (branch_taken) begin
            // The word fetched at the old PC is squashed, whatever it encodes
            pc          <= lut[branch_idx];
            mach_code   <= '0;
            instr_valid <= 1'b0;
          end else if (stall) begin
            pc          <= pc;
          end else if (imem_data == HALT) begin
            state       <= HALTED;
            done        <= 1'b1;
            instr_valid <= 1'b0;
          end else if (imem_data == MODE_SW) begin
            mode        <= ~mode;
            instr_valid <= 1'b0;
            pc          <= pc + PC_W'(1);
          end else begin
            mach_code   <= imem_data;
            instr_valid <= 1'b1;
            pc          <= pc + PC_W'(1);
          end
        end
        HALTED: begin
          if (Start) begin
            state <= RUN;
            pc    <= '0;
            mode  <= 1'b0;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset, Start, stall, branch_taken, lut_we;
  logic [3:0] branch_idx, lut_widx;
  logic [9:0] lut_wdata, imem_addr, pc;
  logic [8:0] imem_data, mach_code;
  logic       mode, instr_valid, done;
  logic [8:0] rom [1024];

  logic       s_start;
  logic [3:0] s_addr, s_pc;
  logic [8:0] s_data, s_mach;
  logic       s_mode, s_valid, s_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  assign imem_data = rom[imem_addr];
  assign s_data    = {5'b0, s_addr} + 9'd1;

  fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .stall(stall),
    .branch_taken(branch_taken), .branch_idx(branch_idx),
    .lut_we(lut_we), .lut_widx(lut_widx), .lut_wdata(lut_wdata),
    .imem_addr(imem_addr), .imem_data(imem_data), .mach_code(mach_code),
    .mode(mode), .instr_valid(instr_valid), .pc(pc), .done(done)
  );

  fetch_unit #(.PC_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(s_start), .stall(1'b0),
    .branch_taken(1'b0), .branch_idx(4'd0),
    .lut_we(1'b0), .lut_widx(4'd0), .lut_wdata(4'd0),
    .imem_addr(s_addr), .imem_data(s_data), .mach_code(s_mach),
    .mode(s_mode), .instr_valid(s_valid), .pc(s_pc), .done(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 1024; i++) rom[i] = {1'b0, i[7:0]};
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_idx = '0; lut_we = 1'b0; lut_widx = '0; lut_wdata = '0; s_start = 1'b0;
    fill_linear();
    rom[0] = 9'h012; rom[1] = 9'h034; rom[2] = 9'h1FF;
    tick(); tick();
    Reset = 1'b0;
    chk("rst_pc", pc, 0);
    chk("rst_mach", mach_code, 0);
    chk("rst_mode", mode, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", imem_addr, 0);

    // Straight run to HALT
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t1_pc0", pc, 0);
    chk("t1_valid0", instr_valid, 0);
    tick();
    chk("t1_mach_a", mach_code, 9'h012);
    chk("t1_valid_a", instr_valid, 1);
    chk("t1_pc1", pc, 1);
    tick();
    chk("t1_mach_b", mach_code, 9'h034);
    chk("t1_valid_b", instr_valid, 1);
    tick();
    chk("t1_valid_h", instr_valid, 0);
    chk("t1_done", done, 1);
    chk("t1_pc_h", pc, 2);
    tick();
    chk("t1_pc_hold", pc, 2);
    chk("t1_done_hold", done, 1);

    // Mode toggle
    rom[0] = 9'h1FE; rom[1] = 9'h0C5; rom[2] = 9'h1FF;
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t2_done_clr", done, 0);
    chk("t2_pc0", pc, 0);
    tick();
    chk("t2_valid_sw", instr_valid, 0);
    chk("t2_mode_sw", mode, 1);
    chk("t2_pc1", pc, 1);
    tick();
    chk("t2_mach", mach_code, 9'h0C5);
    chk("t2_valid", instr_valid, 1);
    chk("t2_mode", mode, 1);
    tick();
    chk("t2_done", done, 1);

    // LUT write while halted, then branch from pc=5
    fill_linear();
    lut_we = 1'b1; lut_widx = 4'd3; lut_wdata = 10'h040; tick(); lut_we = 1'b0;
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t3_mode_clr", mode, 0);
    repeat (5) tick();
    chk("t3_pc5", pc, 5);
    chk("t3_mach4", mach_code, 9'h004);
    branch_taken = 1'b1; branch_idx = 4'd3; tick(); branch_taken = 1'b0;
    chk("t3_pc_br", pc, 10'h040);
    chk("t3_valid_br", instr_valid, 0);
    chk("t3_mach_br", mach_code, 0);
    tick();
    chk("t3_mach_tgt", mach_code, 9'h040);
    chk("t3_valid_tgt", instr_valid, 1);
    chk("t3_pc_tgt", pc, 10'h041);

    // Restart in RUN, then stall at pc=7
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t4_pc_rs", pc, 0);
    chk("t4_valid_rs", instr_valid, 0);
    repeat (7) tick();
    chk("t4_pc7", pc, 7);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_pc_stall", pc, 7);
      chk("t4_mach_stall", mach_code, 9'h006);
      chk("t4_valid_stall", instr_valid, 1);
    end
    branch_taken = 1'b1; branch_idx = 4'd3; tick();
    chk("t4_pc_br_stall", pc, 10'h040);
    chk("t4_valid_br_stall", instr_valid, 0);
    stall = 1'b0;

    // Branch and LUT write to the same entry on one edge uses the old target
    branch_idx = 4'd5; lut_we = 1'b1; lut_widx = 4'd5; lut_wdata = 10'h100; tick();
    lut_we = 1'b0;
    chk("t5_pc_old", pc, 0);
    tick(); branch_taken = 1'b0;
    chk("t5_pc_new", pc, 10'h100);

    // Branch squashes a HALT word at the old PC
    rom[10'h100] = 9'h1FF;
    branch_taken = 1'b1; branch_idx = 4'd3; tick(); branch_taken = 1'b0;
    chk("t6_done_sq", done, 0);
    chk("t6_pc_sq", pc, 10'h040);

    // Reset mid-run with mode set clears outputs and LUT
    rom[0] = 9'h1FE;
    Start = 1'b1; tick(); Start = 1'b0;
    tick();
    chk("t7_mode1", mode, 1);
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk("t7_pc", pc, 0);
    chk("t7_mode", mode, 0);
    chk("t7_valid", instr_valid, 0);
    chk("t7_mach", mach_code, 0);
    chk("t7_done", done, 0);
    branch_taken = 1'b1; branch_idx = 4'd3; tick();
    chk("t7_idle_ignore", pc, 0);
    branch_taken = 1'b0; Start = 1'b1; tick(); Start = 1'b0;
    branch_taken = 1'b1; branch_idx = 4'd5; lut_wdata = 10'h3FF; tick(); branch_taken = 1'b0;
    chk("t7_lut_clr", pc, 0);

    // 4-bit PC wraps from 15 to 0 with no halt
    s_start = 1'b1; tick(); s_start = 1'b0;
    chk("t8_pc0", s_pc, 0);
    repeat (15) tick();
    chk("t8_pc15", s_pc, 15);
    tick();
    chk("t8_pc_wrap", s_pc, 0);
    chk("t8_mach", s_mach, 9'h010);
    chk("t8_valid", s_valid, 1);
    chk("t8_done", s_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
